// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the helper that derives the bit-counter width from the operand width.
package serial_sub_pkg;

    // Sequencer states, 2-bit encoding
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // Counter width able to hold the values 0..w
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/serial_subtractor_fs_bit.sv
// One-bit full subtractor: d = x - y - bin, with borrow out.
module fs_bit (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    // Difference bit and borrow generation/propagation
    always_comb begin
        d    = x ^ y ^ bin;
        bout = (~x & y) | (~(x ^ y) & bin);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b, LSB first, one bit per clock, using a
// single full-subtractor cell and a borrow flip-flop.
// Optional macro SERIAL_SUB_OVF_EN adds the signed-overflow output ovf.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_t             state_reg;
    logic [WIDTH-1:0]   sa_reg;
    logic [WIDTH-1:0]   sb_reg;
    logic [WIDTH-1:0]   diff_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               br_reg;
    logic               borrow_out_reg;
    logic               busy_reg;
    logic               done_reg;
`ifdef SERIAL_SUB_OVF_EN
    logic               ovf_reg;
`endif

    logic               bit_d;
    logic               br_next;

    // The single serial step: current LSBs of both operands plus stored borrow
    fs_bit u_fs_bit (
        .x    (sa_reg[0]),
        .y    (sb_reg[0]),
        .bin  (br_reg),
        .d    (bit_d),
        .bout (br_next)
    );

    // Sequencer, operand/result shift registers, bit counter and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            sa_reg         <= '0;
            sb_reg         <= '0;
            diff_reg       <= '0;
            cnt_reg        <= '0;
            br_reg         <= 1'b0;
            borrow_out_reg <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf_reg        <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    if (start) begin
                        sa_reg    <= a;
                        sb_reg    <= b;
                        br_reg    <= 1'b0;
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b1;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    // Result bits enter at the MSB so the first bit ends up at bit 0
                    diff_reg <= {bit_d, diff_reg[WIDTH-1:1]};
                    sa_reg   <= sa_reg >> 1;
                    sb_reg   <= sb_reg >> 1;
                    br_reg   <= br_next;
                    cnt_reg  <= cnt_reg + CNT_W'(1);
                    if (cnt_reg == CNT_W'(WIDTH - 1)) begin
                        borrow_out_reg <= br_next;
`ifdef SERIAL_SUB_OVF_EN
                        // Borrow into vs. out of the MSB step differ on signed overflow
                        ovf_reg        <= br_reg ^ br_next;
`endif
                        done_reg       <= 1'b1;
                        state_reg      <= DONE;
                    end
                end
                DONE: begin
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign busy       = busy_reg;
    assign done       = done_reg;
    assign diff       = diff_reg;
    assign borrow_out = borrow_out_reg;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf        = ovf_reg;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=8). A reference model decides
// which starts are accepted and predicts results with plain arithmetic; a
// monitor compares whenever done is presented.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow_out;
    logic         ovf;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf        (ovf)
`endif
    );

`ifndef SERIAL_SUB_OVF_EN
    assign ovf = 1'b0;
`endif

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] diff;
        logic         br;
        logic         ov;
        int           done_cyc;
    } exp_t;

    exp_t         q[$];
    int           cyc = 0;
    int           next_ok = 0;
    int           last_accept = -100;
    logic [W-1:0] last_diff = '0;
    logic         last_br = 1'b0;
    logic         last_ov = 1'b0;
    int           n_checks = 0;
    int           n_fail = 0;
    int           n_ops = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: accepts a start only when idle, predicts result and done cycle
    always @(posedge clk) begin
        exp_t e;
        int   d;
        cyc++;
        if (!rst_n) begin
            q.delete();
            next_ok     = 0;
            last_accept = -100;
            last_diff   = '0;
            last_br     = 1'b0;
            last_ov     = 1'b0;
        end else if (start && cyc >= next_ok) begin
            d          = (int'(a) - int'(b) + 256) % 256;
            e.a        = a;
            e.b        = b;
            e.diff     = W'(d);
            e.br       = (a < b);
            e.ov       = (a[W-1] != b[W-1]) && (e.diff[W-1] != a[W-1]);
            e.done_cyc = cyc + W;
            q.push_back(e);
            last_accept = cyc;
            next_ok     = cyc + W + 2;
        end
    end

    // Monitor: busy window, result on done, missing/spurious done, held result in IDLE
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            check("busy", busy, (cyc >= last_accept && cyc <= last_accept + W));
            if (done) begin
                if (q.size() == 0) begin
                    check("spurious_done", done, 0);
                end else begin
                    e = q.pop_front();
                    check("done_cycle", cyc, e.done_cyc);
                    check("diff", diff, e.diff);
                    check("borrow_out", borrow_out, e.br);
`ifdef SERIAL_SUB_OVF_EN
                    check("ovf", ovf, e.ov);
`endif
                    last_diff = e.diff;
                    last_br   = e.br;
                    last_ov   = e.ov;
                    n_ops++;
                    $display("op %0d: a=0x%02h b=0x%02h diff=0x%02h borrow=%0b ovf=%0b",
                             n_ops, e.a, e.b, diff, borrow_out, ovf);
                end
            end else begin
                if (q.size() != 0 && q[0].done_cyc <= cyc) begin
                    check("missing_done", done, 1);
                    void'(q.pop_front());
                end
                if (!busy) begin
                    check("held_diff", diff, last_diff);
                    check("held_borrow", borrow_out, last_br);
`ifdef SERIAL_SUB_OVF_EN
                    check("held_ovf", ovf, last_ov);
`endif
                end
            end
        end
    end

    // One operation: pulse start, then scramble operands while it runs
    task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clk);
        start = 1'b1;
        a = x;
        b = y;
        @(negedge clk);
        start = 1'b0;
        repeat (10) begin
            a = W'($urandom);
            b = W'($urandom);
            @(negedge clk);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_diff"}, diff, 0);
        check({tag, "_borrow"}, borrow_out, 0);
        check({tag, "_ovf"}, ovf, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not complete (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check_zero_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed operands
        do_op(8'h5A, 8'h23);
        do_op(8'h10, 8'h20);
        do_op(8'h00, 8'h00);
        do_op(8'h80, 8'h01);
        do_op(8'hFF, 8'h01);
        do_op(8'h7F, 8'hFF);
        do_op(8'h00, 8'hFF);

        // Start held high with fresh operands every cycle
        @(negedge clk);
        start = 1'b1;
        for (int i = 0; i < 50; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            @(negedge clk);
        end
        start = 1'b0;
        repeat (12) @(negedge clk);

        // Reset during RUN: outputs clear asynchronously, no done pulse
        start = 1'b1;
        a = 8'h5A;
        b = 8'h23;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero_outputs("async_reset");
        repeat (2) @(negedge clk);
        #1;
        check_zero_outputs("held_reset");
        @(negedge clk);
        rst_n = 1'b1;
        do_op(8'h5A, 8'h23);

        // Random sweep
        for (int i = 0; i < 1000; i++) begin
            do_op(W'($urandom), W'($urandom));
        end

        repeat (12) @(negedge clk);
        check("pending_results", q.size(), 0);
        check("op_count_min", (n_ops >= 1008), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
